bullet_fire_controller: RTL and testbench
=========================================

Name: bullet_fire_controller

Overview:
- Upstream of the per-slot bullet engines.
- Turns the player fire button into a single launch request and picks the lowest-index free bullet slot.
- Latches the ship X position and the firing direction, then drives that slot's start_bullet until the slot reports inUse.
- Enforces a refire cooldown, buffers one early press, and keeps shot and drop statistics for the HUD.

Parameters:
- NUM_SLOTS, 4, number of bullet engines served (1..8).
- COOLDOWN_FRAMES, 8, frames between a launch ending and the next launch being accepted (0..255).
- ACK_TIMEOUT, 4, frames to wait for the slot's inUse before the launch is abandoned (1..15).
- BUFFER_SHOT, 1, 1 means a press during ISSUE/COOLDOWN is remembered (one deep); 0 means it is discarded.

Ports:
- clk_60hz  input  1  frame-rate clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- fire_btn  input  1  debounced fire button level.
- direction  input  1  1 = bullet travels up, 0 = down; sampled at request.
- shipX  input  10  ship X position; sampled at request.
- ship_alive  input  1  0 blocks all new launches.
- slot_in_use  input  NUM_SLOTS  inUse flags from the bullet engines.
- start_bullet  output  NUM_SLOTS  one-hot launch strobe, held until acknowledged.
- launch_x  output  10  X position for the launching slot.
- launch_dir  output  1  direction for the launching slot.
- cooldown_active  output  1  high while in COOLDOWN.
- no_slot  output  1  one-cycle pulse: request dropped because all slots were busy.
- launch_fail  output  1  one-cycle pulse: ACK_TIMEOUT expired.
- shots_fired  output  16  count of acknowledged launches, saturating at 16'hFFFF.

Behaviour:
- All outputs are registered.
- Reset values: start_bullet=0, launch_x=0, launch_dir=0, cooldown_active=0, no_slot=0, launch_fail=0, shots_fired=0. Internal state: state=IDLE, pending=0, fire_prev=0, counters=0.
- Edge detect: fire_rise = fire_btn & ~fire_prev. fire_prev is updated every cycle.
- Request: req = (fire_rise | pending) & ship_alive. When ship_alive=0, pending is cleared every cycle.
- IDLE:
  - If req and some slot_in_use bit is 0: sel = lowest free index; latch launch_x=shipX and launch_dir=direction; start_bullet=onehot(sel); clear pending; load the timeout counter; go to ISSUE.
  - If req and all slots are busy: no_slot=1 for one cycle; clear pending; stay in IDLE.
- ISSUE:
  - start_bullet holds its value.
  - Each cycle, check slot_in_use[sel]:
    - If 1 (ack): start_bullet=0; shots_fired+1 (saturating); go to COOLDOWN. If COOLDOWN_FRAMES=0, go directly to IDLE.
    - Else, if the timeout counter expires after ACK_TIMEOUT cycles in ISSUE: start_bullet=0; launch_fail=1 for one cycle; go to COOLDOWN.
  - sel is never re-chosen while in ISSUE.
- Expected latency: press sampled at edge t → start_bullet high after edge t → engine sets inUse at edge t+1 → ack seen at edge t+2 → start_bullet low after edge t+2.
- COOLDOWN:
  - cooldown_active=1 for exactly COOLDOWN_FRAMES cycles, then return to IDLE with cooldown_active=0.
- Buffering:
  - With BUFFER_SHOT=1, a fire_rise in ISSUE or COOLDOWN sets pending (one deep).
  - A second early press is lost.
  - A pending request launches on the first IDLE cycle.
- Only one start_bullet bit is ever high.
- launch_x and launch_dir hold their values until the next launch.
- Reset asserted in any state wins over every other event. start_bullet drops after that edge, and any pending request is lost.

Test Plan:
- Reset, all slots free, fire_btn 0→1 at edge 10 with shipX=320, direction=1, and slot_in_use[0] rising at edge 11 → start_bullet=4'b0001 during cycles 10–11, launch_x=320, launch_dir=1, cleared after edge 12, shots_fired=1, cooldown_active high for exactly 8 cycles.
- slot_in_use=4'b1011, press fire → start_bullet=4'b0100. slot_in_use=4'b1111, press fire → no_slot pulse for 1 cycle, state stays IDLE, shots_fired unchanged.
- Hold fire_btn high for 50 frames → exactly one launch; no auto-repeat.
- Press during cooldown frame 3 with BUFFER_SHOT=1 → launch starts on the first IDLE cycle after cooldown. With BUFFER_SHOT=0 → no launch.
- Slot never acks → start_bullet held for 4 cycles, then launch_fail pulse, then COOLDOWN, with shots_fired unchanged.
- Assert reset mid-ISSUE → start_bullet=0 after the next edge and all outputs return to reset values. Press with ship_alive=0 → no start_bullet and no pending launch afterwards.

Source files
------------

// File: rtl/bullet_fire_controller.sv
// Fire-button front end for the bullet engines: edge-detects the press, picks the
// lowest free slot, strobes it until acknowledged, then enforces a refire cooldown.
module bullet_fire_controller #(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ACK_TIMEOUT     = 4,
    parameter int BUFFER_SHOT     = 1
) (
    input  logic                 clk_60hz,
    input  logic                 reset,
    input  logic                 fire_btn,
    input  logic                 direction,
    input  logic [9:0]           shipX,
    input  logic                 ship_alive,
    input  logic [NUM_SLOTS-1:0] slot_in_use,
    output logic [NUM_SLOTS-1:0] start_bullet,
    output logic [9:0]           launch_x,
    output logic                 launch_dir,
    output logic                 cooldown_active,
    output logic                 no_slot,
    output logic                 launch_fail,
    output logic [15:0]          shots_fired
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0] CD_LOAD     = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] ACK_LOAD    = 8'(ACK_TIMEOUT);
    localparam state_t     AFTER_ISSUE = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;

    state_t               state, state_nxt;
    logic [7:0]           frame_cnt, cnt_nxt;
    logic                 pending, pending_nxt;
    logic                 fire_prev;
    logic                 fire_rise, req, any_free, acked;
    logic                 launch, drop, ack_evt, timeout_evt;
    logic [NUM_SLOTS-1:0] free_slots, free_onehot;
    logic [NUM_SLOTS-1:0] start_nxt;
    logic [9:0]           x_nxt;
    logic                 dir_nxt;
    logic [15:0]          shots_nxt;

    assign fire_rise   = fire_btn & ~fire_prev;
    assign req         = (fire_rise | pending) & ship_alive;
    assign free_slots  = ~slot_in_use;
    assign any_free    = |free_slots;
    // Isolating the lowest set bit of the free mask gives the lowest free slot.
    assign free_onehot = free_slots & (~free_slots + NUM_SLOTS'(1));
    // start_bullet stays one-hot through ISSUE, so it doubles as the latched slot select.
    assign acked       = |(slot_in_use & start_bullet);

    always_ff @(posedge clk_60hz) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            state           <= IDLE;
            frame_cnt       <= '0;
            pending         <= 1'b0;
            fire_prev       <= 1'b0;
            start_bullet    <= '0;
            launch_x        <= '0;
            launch_dir      <= 1'b0;
            cooldown_active <= 1'b0;
            no_slot         <= 1'b0;
            launch_fail     <= 1'b0;
            shots_fired     <= '0;
        end else begin
            state           <= state_nxt;
            frame_cnt       <= cnt_nxt;
            pending         <= pending_nxt;
            fire_prev       <= fire_btn;
            start_bullet    <= start_nxt;
            launch_x        <= x_nxt;
            launch_dir      <= dir_nxt;
            cooldown_active <= (state_nxt == COOLDOWN);
            no_slot         <= drop;
            launch_fail     <= timeout_evt;
            shots_fired     <= shots_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_nxt   = state;
        cnt_nxt     = frame_cnt;
        launch      = 1'b0;
        drop        = 1'b0;
        ack_evt     = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (any_free) begin
                        launch    = 1'b1;
                        state_nxt = ISSUE;
                        cnt_nxt   = ACK_LOAD;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (acked) begin
                    ack_evt   = 1'b1;
                    state_nxt = AFTER_ISSUE;
                    cnt_nxt   = CD_LOAD;
                end else if (frame_cnt <= 8'd1) begin
                    timeout_evt = 1'b1;
                    state_nxt   = AFTER_ISSUE;
                    cnt_nxt     = CD_LOAD;
                end else begin
                    cnt_nxt = frame_cnt - 8'd1;
                end
            end
            COOLDOWN: begin
                if (frame_cnt <= 8'd1) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = frame_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_nxt   = start_bullet;
        x_nxt       = launch_x;
        dir_nxt     = launch_dir;
        shots_nxt   = shots_fired;
        pending_nxt = pending;
        if (launch) begin
            start_nxt = free_onehot;
            x_nxt     = shipX;
            dir_nxt   = direction;
        end
        if (ack_evt || timeout_evt) begin
            start_nxt = '0;
        end
        if (ack_evt && shots_fired != 16'hFFFF) begin
            shots_nxt = shots_fired + 16'd1;
        end
        // A request in IDLE is always consumed, either as a launch or as a drop.
        if (!ship_alive) begin
            pending_nxt = 1'b0;
        end else if (state == IDLE && req) begin
            pending_nxt = 1'b0;
        end else if (state != IDLE && fire_rise && BUFFER_SHOT != 0) begin
            pending_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_bullet_fire_controller.sv
// Directed bench for bullet_fire_controller: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and compares as the DUT produces them.
module tb_bullet_fire_controller;

    localparam int NS = 4;

    logic          clk_60hz     = 1'b0;
    logic          reset        = 1'b1;
    logic          fire_btn     = 1'b0;
    logic          direction    = 1'b0;
    logic [9:0]    shipX        = '0;
    logic          ship_alive   = 1'b1;
    logic [NS-1:0] force_busy   = '0;
    logic          ack_en       = 1'b1;
    logic          engine_clear = 1'b0;
    logic          mirror_nb    = 1'b0;

    logic [NS-1:0] engine_busy, engine_busy_nb;
    logic [NS-1:0] slot_in_use, slot_in_use_nb;
    logic          fire_btn_nb;

    logic [NS-1:0] start_bullet, start_bullet_nb;
    logic [9:0]    launch_x, launch_x_nb;
    logic          launch_dir, launch_dir_nb;
    logic          cooldown_active, cooldown_active_nb;
    logic          no_slot, no_slot_nb;
    logic          launch_fail, launch_fail_nb;
    logic [15:0]   shots_fired, shots_fired_nb;

    assign slot_in_use    = force_busy | engine_busy;
    assign slot_in_use_nb = force_busy | engine_busy_nb;
    assign fire_btn_nb    = fire_btn & mirror_nb;

    always #5 clk_60hz = ~clk_60hz;

    bullet_fire_controller #(
        .NUM_SLOTS(NS), .COOLDOWN_FRAMES(8), .ACK_TIMEOUT(4), .BUFFER_SHOT(1)
    ) dut (
        .clk_60hz(clk_60hz), .reset(reset), .fire_btn(fire_btn), .direction(direction),
        .shipX(shipX), .ship_alive(ship_alive), .slot_in_use(slot_in_use),
        .start_bullet(start_bullet), .launch_x(launch_x), .launch_dir(launch_dir),
        .cooldown_active(cooldown_active), .no_slot(no_slot), .launch_fail(launch_fail),
        .shots_fired(shots_fired)
    );

    bullet_fire_controller #(
        .NUM_SLOTS(NS), .COOLDOWN_FRAMES(8), .ACK_TIMEOUT(4), .BUFFER_SHOT(0)
    ) dut_nb (
        .clk_60hz(clk_60hz), .reset(reset), .fire_btn(fire_btn_nb), .direction(direction),
        .shipX(shipX), .ship_alive(ship_alive), .slot_in_use(slot_in_use_nb),
        .start_bullet(start_bullet_nb), .launch_x(launch_x_nb), .launch_dir(launch_dir_nb),
        .cooldown_active(cooldown_active_nb), .no_slot(no_slot_nb), .launch_fail(launch_fail_nb),
        .shots_fired(shots_fired_nb)
    );

    // Bullet engine model: a slot goes in-use the edge after it sees its start strobe.
    always @(posedge clk_60hz) begin
        if (reset || engine_clear) begin
            engine_busy    <= '0;
            engine_busy_nb <= '0;
        end else if (ack_en) begin
            engine_busy    <= engine_busy | start_bullet;
            engine_busy_nb <= engine_busy_nb | start_bullet_nb;
        end
    end

    typedef enum int {EV_LAUNCH, EV_END, EV_NOSLOT, EV_CDEND} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [NS-1:0] onehot;
        logic [9:0]    x;
        logic          dir;
        int            gap;
        int            hold;
        logic          fail;
        int            shots;
        int            len;
    } ev_t;

    ev_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push_launch(input logic [NS-1:0] oh, input logic [9:0] x, input logic d, input int gap);
        ev_t e;
        e = '{kind: EV_LAUNCH, onehot: oh, x: x, dir: d, gap: gap, hold: 0, fail: 1'b0, shots: 0, len: 0};
        sb.push_back(e);
    endtask

    task automatic push_end(input int hold, input logic fail, input int shots);
        ev_t e;
        e = '{kind: EV_END, onehot: '0, x: '0, dir: 1'b0, gap: -1, hold: hold, fail: fail, shots: shots, len: 0};
        sb.push_back(e);
    endtask

    task automatic push_noslot(input int shots);
        ev_t e;
        e = '{kind: EV_NOSLOT, onehot: '0, x: '0, dir: 1'b0, gap: -1, hold: 0, fail: 1'b0, shots: shots, len: 0};
        sb.push_back(e);
    endtask

    task automatic push_cd(input int len);
        ev_t e;
        e = '{kind: EV_CDEND, onehot: '0, x: '0, dir: 1'b0, gap: -1, hold: 0, fail: 1'b0, shots: 0, len: len};
        sb.push_back(e);
    endtask

    task automatic pop_expect(input ev_kind_t k, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{kind: EV_LAUNCH, onehot: '0, x: '0, dir: 1'b0, gap: -1, hold: 0, fail: 1'b0, shots: 0, len: 0};
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: actual kind=%0d expected no event (t=%0t)", int'(k), $time);
        end else begin
            e = sb.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            ok = (e.kind == k);
        end
    endtask

    // Monitor state
    int            cyc         = 0;
    int            hold_cnt    = 0;
    int            cd_cnt      = 0;
    int            cd_fall_cyc = -100;
    int            nb_launches = 0;
    logic [NS-1:0] prev_start    = '0;
    logic [NS-1:0] prev_start_nb = '0;
    logic          prev_cd       = 1'b0;
    logic          mon_en        = 1'b0;

    always @(negedge clk_60hz) begin
        ev_t e;
        bit  ok;
        cyc++;
        if (mon_en) begin
            if (prev_cd && !cooldown_active) begin
                pop_expect(EV_CDEND, e, ok);
                if (ok) check("cooldown_len", cd_cnt, e.len);
                cd_fall_cyc = cyc;
            end
            if (no_slot) begin
                pop_expect(EV_NOSLOT, e, ok);
                if (ok) begin
                    check("noslot_shots", int'(shots_fired), e.shots);
                    check("noslot_start_idle", int'(start_bullet), 0);
                    check("noslot_cooldown_idle", int'(cooldown_active), 0);
                end
            end
            if (prev_start != '0 && start_bullet == '0) begin
                pop_expect(EV_END, e, ok);
                if (ok) begin
                    check("start_hold_cycles", hold_cnt, e.hold);
                    check("launch_fail_pulse", int'(launch_fail), int'(e.fail));
                    check("shots_after_launch", int'(shots_fired), e.shots);
                end
            end else if (launch_fail) begin
                checks++;
                failures++;
                $display("FAIL stray_launch_fail: actual=1 expected=0 (t=%0t)", $time);
            end
            if (prev_start == '0 && start_bullet != '0) begin
                pop_expect(EV_LAUNCH, e, ok);
                if (ok) begin
                    check("launch_onehot", int'(start_bullet), int'(e.onehot));
                    check("launch_x", int'(launch_x), int'(e.x));
                    check("launch_dir", int'(launch_dir), int'(e.dir));
                    if (e.gap >= 0) check("launch_gap_after_cooldown", cyc - cd_fall_cyc, e.gap);
                end
            end
        end
        hold_cnt = (start_bullet != '0) ? hold_cnt + 1 : 0;
        cd_cnt   = cooldown_active ? cd_cnt + 1 : 0;
        prev_start = start_bullet;
        prev_cd    = cooldown_active;
        if (prev_start_nb == '0 && start_bullet_nb != '0) nb_launches++;
        prev_start_nb = start_bullet_nb;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_60hz);
        #1;
    endtask

    task automatic press();
        fire_btn = 1'b1;
        step(1);
        fire_btn = 1'b0;
    endtask

    task automatic clear_engines();
        engine_clear = 1'b1;
        step(1);
        engine_clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start_bullet"}, int'(start_bullet), 0);
        check({tag, "_launch_x"}, int'(launch_x), 0);
        check({tag, "_launch_dir"}, int'(launch_dir), 0);
        check({tag, "_cooldown_active"}, int'(cooldown_active), 0);
        check({tag, "_no_slot"}, int'(no_slot), 0);
        check({tag, "_launch_fail"}, int'(launch_fail), 0);
        check({tag, "_shots_fired"}, int'(shots_fired), 0);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        @(negedge clk_60hz);
        check_reset_values("reset");
        mon_en = 1'b1;
        step(5);

        // Basic launch into slot 0, ack two edges later, 8-frame cooldown.
        shipX = 10'd320; direction = 1'b1;
        push_launch(4'b0001, 10'd320, 1'b1, -1);
        push_end(2, 1'b0, 1);
        push_cd(8);
        press();
        step(14);
        check("drained_basic", sb.size(), 0);
        clear_engines();

        // Lowest free slot is 2 when slots 0,1,3 are busy.
        force_busy = 4'b1011; shipX = 10'd100; direction = 1'b0;
        push_launch(4'b0100, 10'd100, 1'b0, -1);
        push_end(2, 1'b0, 2);
        push_cd(8);
        press();
        step(14);
        check("drained_slot2", sb.size(), 0);
        clear_engines();

        // All slots busy: single no_slot pulse, no launch, count unchanged.
        force_busy = 4'b1111;
        push_noslot(2);
        press();
        step(3);
        check("noslot_shots_unchanged", int'(shots_fired), 2);
        check("drained_noslot", sb.size(), 0);
        force_busy = 4'b0000;

        // Holding fire for 50 frames yields exactly one launch.
        shipX = 10'd500; direction = 1'b1;
        push_launch(4'b0001, 10'd500, 1'b1, -1);
        push_end(2, 1'b0, 3);
        push_cd(8);
        fire_btn = 1'b1;
        step(50);
        fire_btn = 1'b0;
        step(3);
        check("drained_hold", sb.size(), 0);
        clear_engines();

        // Press in cooldown frame 3 is buffered and launches on the first IDLE cycle.
        mirror_nb = 1'b1; shipX = 10'd200; direction = 1'b1;
        push_launch(4'b0001, 10'd200, 1'b1, -1);
        push_end(2, 1'b0, 4);
        push_cd(8);
        push_launch(4'b0010, 10'd200, 1'b1, 1);
        push_end(2, 1'b0, 5);
        push_cd(8);
        press();
        step(4);
        press();
        step(30);
        check("nobuffer_launch_count", nb_launches, 1);
        check("drained_buffer", sb.size(), 0);
        mirror_nb = 1'b0;
        clear_engines();

        // Slot never acknowledges: 4-cycle strobe, launch_fail pulse, cooldown.
        ack_en = 1'b0; shipX = 10'd77; direction = 1'b0;
        push_launch(4'b0001, 10'd77, 1'b0, -1);
        push_end(4, 1'b1, 5);
        push_cd(8);
        press();
        step(20);
        check("timeout_shots_unchanged", int'(shots_fired), 5);
        check("drained_timeout", sb.size(), 0);

        // Reset in ISSUE with a buffered press: everything clears, nothing relaunches.
        shipX = 10'd600; direction = 1'b1;
        push_launch(4'b0001, 10'd600, 1'b1, -1);
        push_end(3, 1'b0, 0);
        fire_btn = 1'b1;
        step(1);
        fire_btn = 1'b0;
        step(1);
        fire_btn = 1'b1;
        step(1);
        reset = 1'b1; fire_btn = 1'b0;
        step(1);
        reset = 1'b0;
        @(negedge clk_60hz);
        check_reset_values("midreset");
        step(20);
        check("midreset_no_relaunch", int'(start_bullet), 0);
        check("drained_midreset", sb.size(), 0);

        // Press with the ship dead: no launch then or after it comes back.
        ack_en = 1'b1; ship_alive = 1'b0;
        fire_btn = 1'b1;
        step(4);
        ship_alive = 1'b1;
        step(20);
        fire_btn = 1'b0;
        step(3);
        check("dead_ship_no_start", int'(start_bullet), 0);
        check("dead_ship_shots", int'(shots_fired), 0);
        check("drained_dead_ship", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
